// File: rtl/gf180mcu_osu_sc_9t_cplx21_pipe_pkg.sv
// rtl/gf180mcu_osu_sc_9t_cplx21_pipe_pkg.sv - mode encoding and per-lane complex-gate function
package gf180mcu_osu_sc_9t_cplx21_pipe_pkg;

  typedef enum logic [1:0] {
    OAI21 = 2'd0,
    AOI21 = 2'd1,
    OA21  = 2'd2,
    AO21  = 2'd3
  } cplx21_mode_e;

  // Single-lane evaluation; OAI21 is bit-exact with the oai21 standard cell.
  function automatic logic cplx21_eval(input cplx21_mode_e mode, input logic a0,
                                       input logic a1, input logic b);
    logic r;
    case (mode)
      OAI21:   r = ~((a0 | a1) & b);
      AOI21:   r = ~((a0 & a1) | b);
      OA21:    r = (a0 | a1) & b;
      default: r = (a0 & a1) | b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_9t_cplx21_pipe_stage.sv
// rtl/gf180mcu_osu_sc_9t_cplx21_pipe_stage.sv - one elastic valid/ready register slot
module gf180mcu_osu_sc_9t_cplx21_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Slot may load when empty or when its content leaves this same cycle
  always_comb begin
    in_ready = ~valid_q | out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  // Slot register; reset empties it and clears the payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/gf180mcu_osu_sc_9t_cplx21_pipe.sv
// rtl/gf180mcu_osu_sc_9t_cplx21_pipe.sv - pipelined vector OAI21/AOI21/OA21/AO21 gate
module gf180mcu_osu_sc_9t_cplx21_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                         CLK,
  input  logic                         R,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic [1:0]                   MODE,
  input  logic [WIDTH-1:0]             A0,
  input  logic [WIDTH-1:0]             A1,
  input  logic [WIDTH-1:0]             B,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [WIDTH-1:0]             Y,
  output logic [$clog2(STAGES+1)-1:0]  COUNT
);
  import gf180mcu_osu_sc_9t_cplx21_pipe_pkg::*;

  localparam int CW = $clog2(STAGES + 1);

  logic [WIDTH-1:0]             eval_y;
  logic [STAGES:1]              valid_s;
  logic [STAGES:1][WIDTH-1:0]   data_s;
  logic                         in_hs, out_hs;
  logic [CW-1:0]                count_q, count_d;

  // Function is resolved at the input so only the result is stored per slot
  always_comb begin
    eval_y = '0;
    for (int i = 0; i < WIDTH; i++) begin
      eval_y[i] = cplx21_eval(cplx21_mode_e'(MODE), A0[i], A1[i], B[i]);
    end
  end

  genvar k;
  for (k = 1; k <= STAGES; k++) begin : g_stage
    logic             rdy;
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             down_ready;

    if (k == 1) begin : g_first
      assign up_valid = IN_VALID;
      assign up_data  = eval_y;
    end else begin : g_mid
      assign up_valid = valid_s[k-1];
      assign up_data  = data_s[k-1];
    end

    if (k == STAGES) begin : g_last
      assign down_ready = OUT_READY;
    end else begin : g_next
      assign down_ready = g_stage[k+1].rdy;
    end

    gf180mcu_osu_sc_9t_cplx21_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (CLK),
      .rst       (R),
      .in_valid  (up_valid),
      .in_ready  (rdy),
      .in_data   (up_data),
      .out_valid (valid_s[k]),
      .out_ready (down_ready),
      .out_data  (data_s[k])
    );
  end

  assign IN_READY  = g_stage[1].rdy;
  assign OUT_VALID = valid_s[STAGES];
  assign Y         = data_s[STAGES];
  assign in_hs     = IN_VALID & IN_READY;
  assign out_hs    = OUT_VALID & OUT_READY;

  // Occupancy tracks accepts minus deliveries; a simultaneous pair cancels
  always_comb begin
    count_d = count_q;
    if (in_hs && !out_hs) begin
      count_d = count_q + CW'(1);
    end else if (!in_hs && out_hs) begin
      count_d = count_q - CW'(1);
    end
  end

  // Occupancy register
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign COUNT = count_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_9t_cplx21_pipe.sv
// tb/tb_gf180mcu_osu_sc_9t_cplx21_pipe.sv - self-checking bench for the pipelined complex gate
module tb_gf180mcu_osu_sc_9t_cplx21_pipe;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  localparam int CW     = $clog2(STAGES + 1);

  logic             CLK, R, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [1:0]       MODE;
  logic [WIDTH-1:0] A0, A1, B, Y;
  logic [CW-1:0]    COUNT;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] sb[$];
  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] y_prev     = '0;
  logic             last_in_hs, last_out_hs;
  logic [WIDTH-1:0] tt_exp [4] = '{8'h57, 8'h15, 8'hA8, 8'hEA};
  logic [WIDTH-1:0] exp_y;
  int               accepts;

  gf180mcu_osu_sc_9t_cplx21_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .CLK       (CLK),
    .R         (R),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .MODE      (MODE),
    .A0        (A0),
    .A1        (A1),
    .B         (B),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .Y         (Y),
    .COUNT     (COUNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [WIDTH-1:0] ref_gate(input int mode, input logic [WIDTH-1:0] a0,
                                                input logic [WIDTH-1:0] a1,
                                                input logic [WIDTH-1:0] b);
    case (mode)
      0:       return ~((a0 | a1) & b);
      1:       return ~((a0 & a1) | b);
      2:       return (a0 | a1) & b;
      default: return (a0 & a1) | b;
    endcase
  endfunction

  task automatic rand_ops();
    MODE = 2'($urandom_range(0, 3));
    A0   = WIDTH'($urandom);
    A1   = WIDTH'($urandom);
    B    = WIDTH'($urandom);
  endtask

  // Called at a falling edge with inputs applied; checks, updates the model, advances one cycle.
  task automatic step();
    #1;
    check("in_ready", 32'(IN_READY), ((sb.size() < STAGES) || OUT_READY) ? 32'd1 : 32'd0);
    check("count", 32'(COUNT), 32'(sb.size()));
    if (stall_prev) begin
      check("hold_valid", 32'(OUT_VALID), 32'd1);
      check("hold_y", 32'(Y), 32'(y_prev));
    end
    last_in_hs  = IN_VALID && IN_READY;
    last_out_hs = OUT_VALID && OUT_READY;
    if (sb.size() == 0) check("idle_out_valid", 32'(OUT_VALID), 32'd0);
    else if (last_out_hs) check("y_order", 32'(Y), 32'(sb.pop_front()));
    stall_prev = OUT_VALID && !OUT_READY;
    y_prev     = Y;
    if (last_in_hs) sb.push_back(ref_gate(int'(MODE), A0, A1, B));
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drain(input string tag);
    int n;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      step();
      n++;
    end
    #1;
    check({tag, "_drain_count"}, 32'(COUNT), 32'd0);
    check({tag, "_drain_valid"}, 32'(OUT_VALID), 32'd0);
    @(negedge CLK);
  endtask

  initial begin
    // Reset with random activity on the inputs
    R = 1'b1;
    IN_VALID  = 1'($urandom);
    OUT_READY = 1'($urandom);
    rand_ops();
    @(negedge CLK);
    rand_ops();
    @(negedge CLK);
    #1;
    check("rst_y", 32'(Y), 32'd0);
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_count", 32'(COUNT), 32'd0);
    @(negedge CLK);
    R = 1'b0;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    #1;
    check("rst_in_ready", 32'(IN_READY), 32'd1);
    @(negedge CLK);

    // Truth table with fixed operands, one transaction per mode
    for (int m = 0; m < 4; m++) begin
      IN_VALID = 1'b1; OUT_READY = 1'b1;
      A0 = 8'hF0; A1 = 8'hCC; B = 8'hAA; MODE = 2'(m);
      step();
      check("tt_accept", 32'(last_in_hs), 32'd1);
      IN_VALID = 1'b0;
      rand_ops();
      for (int j = 0; j < STAGES - 1; j++) begin
        #1;
        check("tt_early", 32'(OUT_VALID), 32'd0);
        step();
      end
      #1;
      check("tt_valid", 32'(OUT_VALID), 32'd1);
      check("tt_y", 32'(Y), 32'(tt_exp[m]));
      step();
    end
    drain("tt");

    // Back-to-back streaming with cycling mode
    OUT_READY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      IN_VALID = 1'b1;
      rand_ops();
      MODE = 2'(i % 4);
      step();
      check("stream_accept", 32'(last_in_hs), 32'd1);
      if (i >= STAGES) check("stream_out", 32'(last_out_hs), 32'd1);
      if (i >= STAGES - 1) check("stream_count", 32'(COUNT), 32'(STAGES));
    end
    drain("stream");

    // Backpressure: downstream stalled for 10 cycles
    OUT_READY = 1'b0;
    accepts = 0;
    for (int i = 0; i < 10; i++) begin
      IN_VALID = 1'b1;
      rand_ops();
      step();
      accepts += int'(last_in_hs);
    end
    check("bp_accepts", 32'(accepts), 32'(STAGES));
    #1;
    check("bp_in_ready", 32'(IN_READY), 32'd0);
    check("bp_count", 32'(COUNT), 32'(STAGES));
    @(negedge CLK);
    drain("bp");

    // Simultaneous in and out on a full pipeline
    OUT_READY = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      IN_VALID = 1'b1;
      rand_ops();
      step();
    end
    IN_VALID = 1'b1; OUT_READY = 1'b1;
    rand_ops();
    step();
    check("sim_in", 32'(last_in_hs), 32'd1);
    check("sim_out", 32'(last_out_hs), 32'd1);
    IN_VALID = 1'b0; OUT_READY = 1'b0;
    #1;
    check("sim_count", 32'(COUNT), 32'(STAGES));
    check("sim_no_bubble", 32'(OUT_VALID), 32'd1);
    @(negedge CLK);
    drain("sim");

    // Asynchronous reset pulse with two items in flight
    OUT_READY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      IN_VALID = 1'b1;
      rand_ops();
      step();
    end
    IN_VALID = 1'b0;
    #1 R = 1'b1;
    #1;
    check("mr_out_valid", 32'(OUT_VALID), 32'd0);
    check("mr_count", 32'(COUNT), 32'd0);
    check("mr_y", 32'(Y), 32'd0);
    #1 R = 1'b0;
    sb.delete();
    stall_prev = 1'b0;
    @(negedge CLK);
    IN_VALID = 1'b1; OUT_READY = 1'b1;
    rand_ops();
    exp_y = ref_gate(int'(MODE), A0, A1, B);
    step();
    check("mr_accept", 32'(last_in_hs), 32'd1);
    IN_VALID = 1'b0;
    for (int j = 0; j < STAGES - 1; j++) step();
    #1;
    check("mr_after_valid", 32'(OUT_VALID), 32'd1);
    check("mr_after_y", 32'(Y), 32'(exp_y));
    step();
    drain("mr");

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 2) != 0);
      rand_ops();
      step();
    end
    drain("rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
